// File: rtl/pulse_train_pkg.sv
// Shared types and defaults for the pulse train generator.
package pulse_train_pkg;

  localparam int PTG_CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } ptg_state_t;

endpackage

// File: rtl/ptg_down_cnt.sv
// Loadable CW-bit down-counter with a zero flag; holds at zero instead of wrapping.
module ptg_down_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (load)               cnt_q <= load_val;
    else if (en && cnt_q != '0)  cnt_q <= cnt_q - CW'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Generates N high pulses of programmable high/low widths from a single start
// request, with busy/done status and a per-pulse rise strobe.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CW = PTG_CW_DEF
) (
  input  logic          c,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] n_pulses,
  input  logic [CW-1:0] hi_len,
  input  logic [CW-1:0] lo_len,
  output logic          o,
  output logic          rise,
  output logic          busy,
  output logic          done
);

  ptg_state_t    state_q, state_d;
  logic [CW-1:0] hi_q, lo_q, hi_clamp, lo_clamp;
  logic          o_q, rise_q, busy_q, done_q;
  logic          cfg_ld;
  logic          ph_load, ph_en, ph_zero;
  logic [CW-1:0] ph_val;
  logic          pc_load, pc_en, pc_zero;
  logic [CW-1:0] pc_val;

  // A zero width would otherwise make a phase vanish; treat it as one cycle.
  assign hi_clamp = (hi_len == '0) ? CW'(1) : hi_len;
  assign lo_clamp = (lo_len == '0) ? CW'(1) : lo_len;

  always_comb begin
    state_d = state_q;
    cfg_ld  = 1'b0;
    ph_load = 1'b0;
    ph_val  = '0;
    ph_en   = 1'b0;
    pc_load = 1'b0;
    pc_val  = '0;
    pc_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cfg_ld = 1'b1;
          if (n_pulses != '0) begin
            state_d = HIGH;
            ph_load = 1'b1;
            ph_val  = hi_clamp - CW'(1);
            pc_load = 1'b1;
            pc_val  = n_pulses - CW'(1);
          end else begin
            state_d = FIN;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ph_zero) begin
          state_d = LOW;
          ph_load = 1'b1;
          ph_val  = lo_q - CW'(1);
        end else begin
          ph_en = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ph_zero) begin
          // The pulse counter holds the number of pulses still to emit.
          if (!pc_zero) begin
            state_d = HIGH;
            ph_load = 1'b1;
            ph_val  = hi_q - CW'(1);
            pc_en   = 1'b1;
          end else begin
            state_d = FIN;
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      o_q     <= 1'b0;
      rise_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= (state_d == HIGH);
      rise_q  <= (state_d == HIGH) && (state_q != HIGH);
      busy_q  <= (state_d == HIGH) || (state_d == LOW);
      done_q  <= (state_d == FIN);
      if (cfg_ld) begin
        hi_q <= hi_clamp;
        lo_q <= lo_clamp;
      end
    end
  end

  ptg_down_cnt #(.CW(CW)) u_phase_cnt (
    .clk(c), .rst_n(rst_n), .load(ph_load), .load_val(ph_val), .en(ph_en), .zero(ph_zero)
  );

  ptg_down_cnt #(.CW(CW)) u_pulse_cnt (
    .clk(c), .rst_n(rst_n), .load(pc_load), .load_val(pc_val), .en(pc_en), .zero(pc_zero)
  );

  assign o    = o_q;
  assign rise = rise_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: one task per scenario, plus a CW=4 max-length instance.
module tb_pulse_train_gen;

  logic       c = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [7:0] n_pulses = '0, hi_len = '0, lo_len = '0;
  logic       o, rise, busy, done;

  logic       start4 = 1'b0, abort4 = 1'b0;
  logic [3:0] n4 = '0, hi4 = '0, lo4 = '0;
  logic       o4, rise4, busy4, done4;

  int checks = 0;
  int failures = 0;

  always #5 c = ~c;

  pulse_train_gen #(.CW(8)) dut (
    .c(c), .rst_n(rst_n), .start(start), .abort(abort),
    .n_pulses(n_pulses), .hi_len(hi_len), .lo_len(lo_len),
    .o(o), .rise(rise), .busy(busy), .done(done)
  );

  pulse_train_gen #(.CW(4)) dut4 (
    .c(c), .rst_n(rst_n), .start(start4), .abort(abort4),
    .n_pulses(n4), .hi_len(hi4), .lo_len(lo4),
    .o(o4), .rise(rise4), .busy(busy4), .done(done4)
  );

  // Expected {o,rise,busy,done} in cycle k+j of the n=3, hi=2, lo=1 train.
  function automatic logic [3:0] exp_basic(input int j);
    logic [10:1] eo = 10'b0011011011;
    logic [10:1] er = 10'b0001001001;
    logic [10:1] eb = 10'b0111111111;
    logic [10:1] ed = 10'b1000000000;
    if (j < 1 || j > 10) return 4'b0000;
    return {eo[j], er[j], eb[j], ed[j]};
  endfunction

  task automatic arm(input logic [7:0] n, input logic [7:0] h, input logic [7:0] l);
    @(negedge c);
    n_pulses = n; hi_len = h; lo_len = l; start = 1'b1;
    @(posedge c);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    rst_n = 1'b0; start = 1'b1; n_pulses = 8'd3; hi_len = 8'd2; lo_len = 8'd1; abort = 1'b1;
    repeat (2) @(posedge c);
    @(negedge c);
    got = {o, rise, busy, done};
    checks++;
    if (got !== 4'b0000) begin failures++; $display("FAIL reset_hold got=%b exp=0000", got); end
    got = {o4, rise4, busy4, done4};
    checks++;
    if (got !== 4'b0000) begin failures++; $display("FAIL reset_hold4 got=%b exp=0000", got); end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge c);
    got = {o, rise, busy, done};
    checks++;
    if (got !== 4'b0000) begin failures++; $display("FAIL reset_release got=%b exp=0000", got); end
  endtask

  task automatic test_basic;
    logic [3:0] got;
    arm(8'd3, 8'd2, 8'd1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      checks++;
      if (got !== exp_basic(j)) begin
        failures++; $display("FAIL basic k+%0d got=%b exp=%b", j, got, exp_basic(j));
      end
    end
  endtask

  task automatic test_zero_n;
    logic [3:0] got, exp;
    arm(8'd0, 8'd5, 8'd5);
    for (int j = 1; j <= 3; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      exp = (j == 1) ? 4'b0001 : 4'b0000;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL zero_n k+%0d got=%b exp=%b", j, got, exp); end
    end
  endtask

  task automatic test_zero_len;
    logic [3:0] got, exp;
    logic [6:1] eo = 6'b000101;
    logic [6:1] er = 6'b000101;
    logic [6:1] eb = 6'b001111;
    logic [6:1] ed = 6'b010000;
    arm(8'd2, 8'd0, 8'd0);
    for (int j = 1; j <= 6; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      exp = {eo[j], er[j], eb[j], ed[j]};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL zero_len k+%0d got=%b exp=%b", j, got, exp); end
    end
  endtask

  task automatic test_start_busy;
    logic [3:0] got;
    arm(8'd3, 8'd2, 8'd1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      checks++;
      if (got !== exp_basic(j)) begin
        failures++; $display("FAIL start_busy k+%0d got=%b exp=%b", j, got, exp_basic(j));
      end
      if (j == 3) begin start = 1'b1; n_pulses = 8'd1; hi_len = 8'd7; lo_len = 8'd7; end
      if (j == 4) start = 1'b0;
    end
  endtask

  task automatic test_abort;
    logic [3:0] got, exp;
    arm(8'd3, 8'd2, 8'd1);
    for (int j = 1; j <= 17; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      exp = (j <= 4) ? exp_basic(j) : (j <= 6) ? 4'b0000 : exp_basic(j - 6);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL abort k+%0d got=%b exp=%b", j, got, exp); end
      if (j == 4) abort = 1'b1;
      if (j == 5) abort = 1'b0;
      if (j == 6) begin start = 1'b1; n_pulses = 8'd3; hi_len = 8'd2; lo_len = 8'd1; end
      if (j == 7) start = 1'b0;
    end
  endtask

  task automatic test_abort_start_idle;
    logic [3:0] got;
    @(negedge c);
    n_pulses = 8'd3; hi_len = 8'd2; lo_len = 8'd1; start = 1'b1; abort = 1'b1;
    @(posedge c);
    #1 begin start = 1'b0; abort = 1'b0; end
    for (int j = 1; j <= 3; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      checks++;
      if (got !== 4'b0000) begin failures++; $display("FAIL abort_start k+%0d got=%b exp=0000", j, got); end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] got, exp;
    arm(8'd3, 8'd2, 8'd1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      exp = (j <= 5) ? exp_basic(j) : 4'b0000;
      checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_mid k+%0d got=%b exp=%b", j, got, exp); end
      if (j == 5) rst_n = 1'b0;
      if (j == 7) rst_n = 1'b1;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got, exp;
    arm(8'd3, 8'd2, 8'd1);
    for (int j = 1; j <= 22; j++) begin
      @(negedge c);
      got = {o, rise, busy, done};
      exp = (j <= 11) ? exp_basic(j) : exp_basic(j - 11);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL back_to_back k+%0d got=%b exp=%b", j, got, exp); end
      // Held across the FIN edge (must be ignored) and the following IDLE edge.
      if (j == 10) start = 1'b1;
      if (j == 12) start = 1'b0;
    end
  endtask

  task automatic test_max;
    logic o_prev;
    int rises, busy_n, done_n, done_at;
    rises = 0; busy_n = 0; done_n = 0; done_at = 0; o_prev = 1'b0;
    @(negedge c);
    n4 = 4'd15; hi4 = 4'd15; lo4 = 4'd15; start4 = 1'b1;
    @(posedge c);
    #1 start4 = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge c);
      checks++;
      if (rise4 !== (o4 & ~o_prev)) begin
        failures++; $display("FAIL max_rise_edge k+%0d rise=%b o=%b o_prev=%b", cyc, rise4, o4, o_prev);
      end
      o_prev = o4;
      if (rise4) rises++;
      if (busy4) busy_n++;
      if (done4) begin done_n++; done_at = cyc; end
      if (done_n > 0 && cyc > done_at + 3) break;
    end
    checks++;
    if (rises != 15) begin failures++; $display("FAIL max_rises got=%0d exp=15", rises); end
    checks++;
    if (busy_n != 450) begin failures++; $display("FAIL max_busy got=%0d exp=450", busy_n); end
    checks++;
    if (done_n != 1) begin failures++; $display("FAIL max_done_count got=%0d exp=1", done_n); end
    checks++;
    if (done_at != 451) begin failures++; $display("FAIL max_done_cycle got=%0d exp=451", done_at); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_n();
    test_zero_len();
    test_start_busy();
    test_abort();
    test_abort_start_idle();
    test_reset_mid();
    test_back_to_back();
    test_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
